mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port data memory between two datapath requesters:
//   port 0 = instruction fetch, port 1 = load/store unit.
//   Round-robin arbitration on ties. Reads are tracked through the memory's
//   fixed read latency, and the response is routed back to the requester that
//   issued it. Sits between the CPU datapath and the block-RAM wrapper.
// PARAMETERS
//   WIDTH        16  data width of wdata/rdata
//   ADDR_WIDTH   16  address width
//   MEM_LATENCY  1   cycles from issue to mem_rdata valid; legal range 1..3
// PORTS
//   c          in   1           clock; all state updates on posedge
//   r          in   1           reset, asynchronous, active-low
//   req0       in   1           port 0 request; addr0/we0/wdata0 held stable until gnt0
//   we0        in   1           port 0 write enable (1 = write, 0 = read)
//   addr0      in   ADDR_WIDTH  port 0 address
//   wdata0     in   WIDTH       port 0 write data
//   gnt0       out  1           port 0 request accepted this cycle
//   rvalid0    out  1           rdata holds port 0 read result this cycle
//   req1, we1, addr1, wdata1, gnt1, rvalid1   same as port 0, for port 1
//   rdata      out  WIDTH       read data, shared; qualified by rvalid0/rvalid1
//   mem_en     out  1           memory access strobe
//   mem_we     out  1           memory write enable
//   mem_addr   out  ADDR_WIDTH  memory address
//   mem_wdata  out  WIDTH       memory write data
//   mem_rdata  in   WIDTH       memory read data, valid MEM_LATENCY cycles after issue
// BEHAVIOUR
//   - Reset (r=0, takes effect asynchronously):
//       state=IDLE, last=1 (port 0 wins the first tie), latency counter=0,
//       rvalid0=rvalid1=0.
//       gnt0=gnt1=mem_en=mem_we=0 while r=0.
//       A read in flight is discarded and no rvalid is produced.
//   - States:
//       IDLE      no read outstanding
//       RD_WAIT   read outstanding; counter runs
//   - Grant logic (combinational, same cycle as req):
//       allowed when state=IDLE, or in RD_WAIT on the cycle the response returns.
//       Only one requester -> grant it.
//       Both requesting -> grant the port != last.
//       On each grant, last <= granted port.
//   - mem_en = gnt0|gnt1.
//       mem_we/mem_addr/mem_wdata come from the granted port.
//       When nothing is granted, these outputs are 0.
//   - Write:
//       completes in its grant cycle; no rvalid.
//       State is unchanged, so back-to-back writes run one per cycle.
//   - Read granted at cycle T:
//       state -> RD_WAIT, counter loaded with MEM_LATENCY.
//       Counter decrements each cycle.
//       At T+MEM_LATENCY: rvalid<owner>=1 for exactly one cycle, and rdata=mem_rdata.
//   - At T+MEM_LATENCY a new grant is permitted in the same cycle (pipelined turnaround):
//       new read  -> RD_WAIT is reloaded
//       new write -> RD_WAIT is left
//       no grant  -> IDLE
//   - During RD_WAIT before the return cycle: gnt0=gnt1=0; requests stall.
//   - rdata = 0 when neither rvalid is asserted.
//   - Never true in any cycle: gnt0&gnt1; rvalid0&rvalid1.
//   - A req dropped before its grant is legal and is simply not serviced.
// TESTING
//   1. Reset: r=0 mid-read (MEM_LATENCY=2, read issued 1 cycle before)
//      -> gnt*/mem_en/rvalid* 0 immediately; no rvalid after release.
//   2. Single read: req0=1, we0=0, addr0=16'h0040, mem returns 16'hBEEF
//      -> gnt0 at T, mem_addr=16'h0040;
//      rvalid0=1, rdata=16'hBEEF at T+MEM_LATENCY.
//   3. Tie after reset: req0=req1=1, both writes (addr 16'h0010 / 16'h0020)
//      -> gnt0 cycle 0, gnt1 cycle 1, mem_addr 16'h0010 then 16'h0020.
//   4. Fairness: req0, req1 held high, all reads, MEM_LATENCY=1, for 8 grants
//      -> grants alternate 0,1,0,1...; one new grant per cycle;
//      each rvalid tagged to the correct port.
//   5. Stall: MEM_LATENCY=3; port 1 read at T; port 0 write requested T+1
//      -> gnt0 held 0 at T+1 and T+2; gnt0=1 at T+3 together with rvalid1.
//   6. Back-to-back writes: port 1 writes 16'h0001..16'h0004 on 4 consecutive cycles
//      -> 4 consecutive gnt1; mem_we=1 each cycle; no rvalid.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port 0 is fetch,
// port 1 is load/store. Round-robin on ties, reads tracked through a fixed latency.
module mem_arbiter #(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  c,
  input  logic                  r,
  // Handshake: a port raises reqN with weN/addrN/wdataN and holds them stable
  // until gntN is seen high in the same cycle; that cycle is the transfer.
  // A read result comes back later as rvalidN with rdata, exactly one cycle.
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0]      wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]      wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [WIDTH-1:0]      rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [0:0]            dbg_state_o
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_WAIT = 1'b1;
  localparam logic [1:0] LAT        = 2'(MEM_LATENCY);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 3) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be in 1..3");
  end

  logic [0:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       owner_q, owner_d;

  logic       ret_w;
  logic       allow_w;
  logic       pick1_w;
  logic       gnt_any_w;
  logic       gnt_we_w;

  // ret_w marks the cycle the outstanding read's data is on mem_rdata; a new
  // grant is allowed in that same cycle so reads can issue back to back.
  assign ret_w   = (state_q == ST_RD_WAIT) && (cnt_q == 2'd1);
  assign allow_w = r && ((state_q == ST_IDLE) || ret_w);
  assign pick1_w = (req0 && req1) ? ~last_q : req1;

  assign gnt0      = allow_w && req0 && !pick1_w;
  assign gnt1      = allow_w && req1 && pick1_w;
  assign gnt_any_w = gnt0 || gnt1;
  assign gnt_we_w  = gnt1 ? we1 : we0;

  always_comb begin
    mem_en    = gnt_any_w;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end
  end

  assign rvalid0     = ret_w && !owner_q;
  assign rvalid1     = ret_w && owner_q;
  assign rdata       = ret_w ? mem_rdata : '0;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    if (gnt_any_w) begin
      last_d = gnt1;
    end
    if (gnt_any_w && !gnt_we_w) begin
      state_d = ST_RD_WAIT;
      cnt_d   = LAT;
      owner_d = gnt1;
    end else if (ret_w) begin
      // Response delivered; a write granted alongside it needs no tracking.
      state_d = ST_IDLE;
      cnt_d   = 2'd0;
    end else if (state_q == ST_RD_WAIT) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  a_one_grant : assert property (@(posedge c) disable iff (!r) !(gnt0 && gnt1));
  a_one_rvalid : assert property (@(posedge c) disable iff (!r) !(rvalid0 && rvalid1));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (latency 1, 2, 3) share
// stimulus; a vector table drives the latency-1 instance, hand sequences the rest.
module tb_mem_arbiter;

  logic        c;
  logic        r;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1, mem_rdata;

  logic [2:0]       gnt0_w, gnt1_w, rv0_w, rv1_w, en_w, we_w;
  logic [2:0][15:0] maddr_w, mwdata_w, rdata_w;
  logic [2:0][0:0]  dbg_w;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        req0, we0;
    logic [15:0] addr0, wdata0;
    logic        req1, we1;
    logic [15:0] addr1, wdata1, mrd;
    logic        g0, g1, rv0, rv1, en, we;
    logic [15:0] maddr, mwdata, rdata;
  } vec_t;

  vec_t tbl[20];

  initial c = 1'b0;
  always #5 c = ~c;

  mem_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(1)) u_lat1 (
    .c(c), .r(r),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0_w[0]), .rvalid0(rv0_w[0]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_w[0]), .rvalid1(rv1_w[0]),
    .rdata(rdata_w[0]), .mem_en(en_w[0]), .mem_we(we_w[0]), .mem_addr(maddr_w[0]),
    .mem_wdata(mwdata_w[0]), .mem_rdata(mem_rdata), .dbg_state_o(dbg_w[0])
  );

  mem_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(2)) u_lat2 (
    .c(c), .r(r),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0_w[1]), .rvalid0(rv0_w[1]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_w[1]), .rvalid1(rv1_w[1]),
    .rdata(rdata_w[1]), .mem_en(en_w[1]), .mem_we(we_w[1]), .mem_addr(maddr_w[1]),
    .mem_wdata(mwdata_w[1]), .mem_rdata(mem_rdata), .dbg_state_o(dbg_w[1])
  );

  mem_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(3)) u_lat3 (
    .c(c), .r(r),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0_w[2]), .rvalid0(rv0_w[2]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_w[2]), .rvalid1(rv1_w[2]),
    .rdata(rdata_w[2]), .mem_en(en_w[2]), .mem_we(we_w[2]), .mem_addr(maddr_w[2]),
    .mem_wdata(mwdata_w[2]), .mem_rdata(mem_rdata), .dbg_state_o(dbg_w[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(
    input logic r0, w0, input logic [15:0] a0, d0,
    input logic r1, w1, input logic [15:0] a1, d1, mrd,
    input logic g0, g1, v0, v1, en, we,
    input logic [15:0] maddr, mwdata, rdata);
    vec_t v;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1; v.mrd = mrd;
    v.g0 = g0; v.g1 = g1; v.rv0 = v0; v.rv1 = v1; v.en = en; v.we = we;
    v.maddr = maddr; v.mwdata = mwdata; v.rdata = rdata;
    return v;
  endfunction

  task automatic clear_inputs();
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; mem_rdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    r = 1'b0;
    clear_inputs();
    next_cycle();
    r = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Tie writes, single read, fairness reads, back-to-back writes on latency 1.
    tbl[0]  = mk(1,1,16'h0010,16'hA0A0, 1,1,16'h0020,16'hB0B0, 16'h0000, 1,0,0,0,1,1,16'h0010,16'hA0A0,16'h0000);
    tbl[1]  = mk(1,1,16'h0010,16'hA0A0, 1,1,16'h0020,16'hB0B0, 16'h0000, 0,1,0,0,1,1,16'h0020,16'hB0B0,16'h0000);
    tbl[2]  = mk(1,1,16'h0010,16'hA0A0, 0,0,16'h0000,16'h0000, 16'h0000, 1,0,0,0,1,1,16'h0010,16'hA0A0,16'h0000);
    tbl[3]  = mk(1,0,16'h0040,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 1,0,0,0,1,0,16'h0040,16'h0000,16'h0000);
    tbl[4]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'hBEEF, 0,0,1,0,0,0,16'h0000,16'h0000,16'hBEEF);
    tbl[5]  = mk(0,0,16'h0000,16'h0000, 1,1,16'h0099,16'h5555, 16'h1234, 0,1,0,0,1,1,16'h0099,16'h5555,16'h0000);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] mrd;
      mrd = 16'((k + 1) * 16'h1111);
      tbl[6+k] = mk(1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, mrd,
                    (k % 2 == 0), (k % 2 == 1), (k % 2 == 1), (k > 0 && k % 2 == 0), 1, 0,
                    (k % 2 == 1) ? 16'h0200 : 16'h0100, 16'h0000, (k > 0) ? mrd : 16'h0000);
    end
    tbl[14] = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h9999, 0,0,0,1,0,0,16'h0000,16'h0000,16'h9999);
    for (int j = 1; j <= 4; j++) begin
      tbl[14+j] = mk(0,0,16'h0000,16'h0000, 1,1,16'(j),16'(16'hD000 + j), 16'hFFFF,
                     0,1,0,0,1,1,16'(j),16'(16'hD000 + j),16'h0000);
    end
    tbl[19] = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'hFFFF, 0,0,0,0,0,0,16'h0000,16'h0000,16'h0000);

    // Reset state, with a request present to confirm grants are held off.
    r = 1'b0;
    clear_inputs();
    req0 = 1'b1;
    @(negedge c);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset gnt0[%0d]", i), 32'(gnt0_w[i]), 0);
      chk($sformatf("reset mem_en[%0d]", i), 32'(en_w[i]), 0);
      chk($sformatf("reset rvalid[%0d]", i), {30'd0, rv0_w[i], rv1_w[i]}, 0);
      chk($sformatf("reset state[%0d]", i), 32'(dbg_w[i]), 0);
    end
    req0 = 1'b0;
    next_cycle();
    r = 1'b1;

    for (int i = 0; i < 20; i++) begin
      next_cycle();
      req0 = tbl[i].req0; we0 = tbl[i].we0; addr0 = tbl[i].addr0; wdata0 = tbl[i].wdata0;
      req1 = tbl[i].req1; we1 = tbl[i].we1; addr1 = tbl[i].addr1; wdata1 = tbl[i].wdata1;
      mem_rdata = tbl[i].mrd;
      @(negedge c);
      chk($sformatf("v%0d gnt0", i), 32'(gnt0_w[0]), 32'(tbl[i].g0));
      chk($sformatf("v%0d gnt1", i), 32'(gnt1_w[0]), 32'(tbl[i].g1));
      chk($sformatf("v%0d rvalid0", i), 32'(rv0_w[0]), 32'(tbl[i].rv0));
      chk($sformatf("v%0d rvalid1", i), 32'(rv1_w[0]), 32'(tbl[i].rv1));
      chk($sformatf("v%0d mem_en", i), 32'(en_w[0]), 32'(tbl[i].en));
      chk($sformatf("v%0d mem_we", i), 32'(we_w[0]), 32'(tbl[i].we));
      chk($sformatf("v%0d mem_addr", i), 32'(maddr_w[0]), 32'(tbl[i].maddr));
      chk($sformatf("v%0d mem_wdata", i), 32'(mwdata_w[0]), 32'(tbl[i].mwdata));
      chk($sformatf("v%0d rdata", i), 32'(rdata_w[0]), 32'(tbl[i].rdata));
    end

    // Reset in the middle of a latency-2 read.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
    @(negedge c);
    chk("rst issue gnt0", 32'(gnt0_w[1]), 1);
    next_cycle();
    req0 = 1'b0;
    #1;
    r = 1'b0;
    req0 = 1'b1;
    #1;
    chk("rst mid gnt0", 32'(gnt0_w[1]), 0);
    chk("rst mid mem_en", 32'(en_w[1]), 0);
    chk("rst mid mem_we", 32'(we_w[1]), 0);
    chk("rst mid rvalid", {30'd0, rv0_w[1], rv1_w[1]}, 0);
    next_cycle();
    req0 = 1'b0;
    next_cycle();
    r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge c);
      chk($sformatf("rst after rvalid %0d", i), {30'd0, rv0_w[1], rv1_w[1]}, 0);
      next_cycle();
    end

    // Stall on latency 3: port 1 read, port 0 write waits for the return cycle.
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0300;
    @(negedge c);
    chk("stall T gnt1", 32'(gnt1_w[2]), 1);
    chk("stall T mem_addr", 32'(maddr_w[2]), 32'h0300);
    next_cycle();
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0400; wdata0 = 16'hCAFE;
    @(negedge c);
    chk("stall T+1 gnt0", 32'(gnt0_w[2]), 0);
    chk("stall T+1 mem_en", 32'(en_w[2]), 0);
    chk("stall T+1 state", 32'(dbg_w[2]), 1);
    next_cycle();
    @(negedge c);
    chk("stall T+2 gnt0", 32'(gnt0_w[2]), 0);
    chk("stall T+2 rvalid1", 32'(rv1_w[2]), 0);
    next_cycle();
    mem_rdata = 16'hF00D;
    @(negedge c);
    chk("stall T+3 gnt0", 32'(gnt0_w[2]), 1);
    chk("stall T+3 rvalid1", 32'(rv1_w[2]), 1);
    chk("stall T+3 rvalid0", 32'(rv0_w[2]), 0);
    chk("stall T+3 rdata", 32'(rdata_w[2]), 32'hF00D);
    chk("stall T+3 mem_we", 32'(we_w[2]), 1);
    chk("stall T+3 mem_addr", 32'(maddr_w[2]), 32'h0400);
    chk("stall T+3 mem_wdata", 32'(mwdata_w[2]), 32'hCAFE);
    next_cycle();
    req0 = 1'b0; we0 = 1'b0; mem_rdata = 16'h0000;
    @(negedge c);
    chk("stall T+4 state", 32'(dbg_w[2]), 0);
    chk("stall T+4 rvalid", {30'd0, rv0_w[2], rv1_w[2]}, 0);

    // Single read through the latency-2 instance.
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
    @(negedge c);
    chk("rd2 gnt0", 32'(gnt0_w[1]), 1);
    chk("rd2 mem_addr", 32'(maddr_w[1]), 32'h0040);
    next_cycle();
    req0 = 1'b0;
    @(negedge c);
    chk("rd2 T+1 rvalid0", 32'(rv0_w[1]), 0);
    next_cycle();
    mem_rdata = 16'hBEEF;
    @(negedge c);
    chk("rd2 T+2 rvalid0", 32'(rv0_w[1]), 1);
    chk("rd2 T+2 rvalid1", 32'(rv1_w[1]), 0);
    chk("rd2 T+2 rdata", 32'(rdata_w[1]), 32'hBEEF);
    next_cycle();
    @(negedge c);
    chk("rd2 T+3 rvalid0", 32'(rv0_w[1]), 0);
    chk("rd2 T+3 rdata", 32'(rdata_w[1]), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
